pattern_select_ctrl: RTL and testbench
======================================

Name: pattern_select_ctrl

Overview:
- Upstream control stage for the video pattern generator. It turns raw push-button inputs into a frame-aligned pattern_select index.
- Two modes: manual (a button advances the pattern) and auto (the pattern advances every AUTO_FRAMES frames).
- Pattern changes take effect only at a vertical-sync frame boundary, so no frame is ever drawn with a mid-frame pattern switch.
- Runs in the 25.2 MHz pixel-clock domain, alongside the pattern generator.

Parameters:
- NUM_PATTERNS, 4: number of selectable patterns; legal range 2..4; index wraps at NUM_PATTERNS-1.
- DEBOUNCE_CYCLES, 252000: consecutive stable cycles required to accept a button level change (10 ms at 25.2 MHz).
- AUTO_FRAMES, 120: frames per pattern in auto mode (2 s at 60 Hz); minimum 1.
- VS_ACTIVE_LOW, 1: 1 = frame start is the falling edge of i_vs; 0 = rising edge.

Ports:
- clk, input, 1: 25.2 MHz pixel clock.
- rst, input, 1: synchronous, active-high reset.
- i_btn_next, input, 1: raw asynchronous button, active-high; advances the pattern.
- i_btn_mode, input, 1: raw asynchronous button, active-high; toggles manual/auto mode.
- i_vs, input, 1: vertical sync from the pattern generator, synchronous to clk.
- o_pattern_select, output, 2: pattern index presented to the pattern generator.
- o_auto_mode, output, 1: 1 while in AUTO.
- o_pending, output, 1: an advance request is waiting for the next frame start.

Behaviour:
- Reset (rst=1 at a clk edge): all of the following are cleared:
  - o_pattern_select=0, o_auto_mode=0 (state MANUAL), o_pending=0.
  - Frame counter=0.
  - Synchronizer flops, debounced levels, debounce counters and the i_vs delay flop.
- Reset asserted mid-debounce or mid-count discards all progress; no press is generated on release of reset.

Input conditioning (per button):
- Two-flop synchronizer.
- Debounce counter: while the synced level differs from the debounced level, count up; when the count reaches DEBOUNCE_CYCLES-1, load the new level and clear the counter. Any cycle where they match clears the counter.
- A 0->1 transition of the debounced level produces a one-cycle press pulse; a 1->0 transition produces nothing.
- Press latency from a raw edge: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.

Frame start (fs):
- vs_d is i_vs registered.
- VS_ACTIVE_LOW=1: fs = vs_d & ~i_vs. VS_ACTIVE_LOW=0: fs = ~vs_d & i_vs.
- fs is combinational in the cycle i_vs first shows its active level.

FSM (states MANUAL, AUTO):
- A mode press toggles the state at the next edge and clears the frame counter.
- o_pending is preserved across a mode toggle.

Pending request:
- A next press sets o_pending. Multiple presses before a frame start collapse into a single advance.

At fs (the update is visible on the edge ending the fs cycle, i.e. 1-cycle latency):
- If o_pending=1 (either mode):
  - Pattern = (pattern+1) mod NUM_PATTERNS, o_pending cleared, frame counter cleared.
- Else, in AUTO:
  - If frame counter == AUTO_FRAMES-1: pattern advances and the counter clears.
  - Otherwise the counter increments.
- Else, in MANUAL: no change; the counter holds at 0.

Simultaneous events:
- Next press in the same cycle as fs: that fs does not consume it. o_pending sets and the advance occurs at the following fs.
- Mode press in the same cycle as fs: the fs action uses the current state; the toggle and counter clear take priority over the counter update.
- Both buttons pressed in the same cycle: both take effect independently.

Wrap: index NUM_PATTERNS-1 advances to 0; values >= NUM_PATTERNS never appear.

Output widths: o_pattern_select is always 2 bits; upper values are unused when NUM_PATTERNS<4.

Decomposition:
- Package pattern_ctrl_pkg:
  - Mode state enum (MANUAL, AUTO).
  - PATTERN_W=2.
  - Default constants CLK_HZ_25_2M=25200000 and DEBOUNCE_10MS=252000.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, i_raw, o_level, o_press), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_PATTERNS=4, VS_ACTIVE_LOW=1, i_vs low for 2 cycles every 20):
- Reset: hold rst 3 cycles with buttons toggling -> o_pattern_select=0, o_auto_mode=0, o_pending=0; no press pulse after release.
- Bounce: i_btn_next glitches high for 3 cycles, then steady high 10 cycles -> exactly one press; o_pending=1 at cycle 2+4+1 after the steady edge. At the next i_vs fall, o_pattern_select 0->1 one cycle later and o_pending=0.
- Collapse and simultaneity: three clean presses within one frame -> a single advance 1->2. A press whose pulse coincides with fs -> no change that frame; change at the following fs.
- Wrap: four manual advances from 0 -> sequence 1,2,3,0.
- Auto: mode press, then 9 frames -> pattern advances on the 3rd, 6th and 9th fs after entry. A next press mid-count -> advance at the next fs and counter restarts (next auto advance 3 frames later).
- Reset mid-operation: rst during AUTO with o_pending=1 -> returns to MANUAL, pattern 0, pending 0; subsequent fs edges produce no change.

Source files
------------

// File: rtl/pattern_select_ctrl_pkg.sv
// Shared types and constants for the pattern-select control block.
package pattern_ctrl_pkg;

    localparam int unsigned PATTERN_W     = 2;
    localparam int unsigned CLK_HZ_25_2M  = 25_200_000;
    localparam int unsigned DEBOUNCE_10MS = 252_000;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

    // Next pattern index, wrapping at num-1 (out-of-range indices also wrap to 0).
    function automatic logic [PATTERN_W-1:0] next_pattern(
        input logic [PATTERN_W-1:0] cur,
        input int unsigned          num
    );
        return (cur >= PATTERN_W'(num - 1)) ? '0 : cur + PATTERN_W'(1);
    endfunction

endpackage

// File: rtl/pattern_select_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce, press pulse.
module btn_debounce
    import pattern_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchronizer chain, debounced level, counter and press pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/pattern_select_ctrl.sv
// Frame-aligned pattern selector: manual/auto advance, applied only at frame start.
module pattern_select_ctrl
    import pattern_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned AUTO_FRAMES     = 120,
    parameter bit          VS_ACTIVE_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_btn_next,
    input  logic                 i_btn_mode,
    input  logic                 i_vs,
    output logic [PATTERN_W-1:0] o_pattern_select,
    output logic                 o_auto_mode,
    output logic                 o_pending
);

    localparam int unsigned FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_FRAMES - 1);

    logic                 next_press;
    logic                 mode_press;
    logic                 next_level;
    logic                 mode_level;
    logic                 unused_levels;
    logic                 vs_d_q;
    logic                 fs_c;
    mode_e                state_q;
    mode_e                state_d;
    logic [PATTERN_W-1:0] pattern_q;
    logic [PATTERN_W-1:0] pattern_d;
    logic                 pending_q;
    logic                 pending_d;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [FCNT_W-1:0]    fcnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_next (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (i_btn_next),
        .o_level (next_level),
        .o_press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_mode (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (i_btn_mode),
        .o_level (mode_level),
        .o_press (mode_press)
    );

    // Debounced levels are not needed here; only the press pulses drive control.
    assign unused_levels = next_level ^ mode_level;

    // Frame start is the first cycle i_vs shows its active level.
    assign fs_c = VS_ACTIVE_LOW ? (vs_d_q & ~i_vs) : (~vs_d_q & i_vs);

    // State register plus pattern, pending, frame counter and vsync delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MANUAL;
            pattern_q <= '0;
            pending_q <= 1'b0;
            fcnt_q    <= '0;
            vs_d_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            pending_q <= pending_d;
            fcnt_q    <= fcnt_d;
            vs_d_q    <= i_vs;
        end
    end

    // Next-state: frame-start action first, then press effects override it.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        pending_d = pending_q;
        fcnt_d    = fcnt_q;

        if (fs_c) begin
            if (pending_q) begin
                pattern_d = next_pattern(pattern_q, NUM_PATTERNS);
                pending_d = 1'b0;
                fcnt_d    = '0;
            end else if (state_q == AUTO) begin
                if (fcnt_q == FCNT_LAST) begin
                    pattern_d = next_pattern(pattern_q, NUM_PATTERNS);
                    fcnt_d    = '0;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end else begin
                fcnt_d = '0;
            end
        end

        // A press coinciding with fs is not consumed by it; it waits for the next one.
        if (next_press) begin
            pending_d = 1'b1;
        end

        if (mode_press) begin
            state_d = (state_q == AUTO) ? MANUAL : AUTO;
            fcnt_d  = '0;
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        o_pattern_select = pattern_q;
        o_auto_mode      = (state_q == AUTO);
        o_pending        = pending_q;
    end

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Self-checking bench for pattern_select_ctrl with a window-based reference model.
module tb_pattern_select_ctrl;

    localparam int unsigned DC  = 4;
    localparam int unsigned AF  = 3;
    localparam int unsigned NP  = 4;
    localparam bit          VAL = 1'b1;
    localparam int unsigned FRAME = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn_next;
    logic       i_btn_mode;
    logic       i_vs;
    logic [1:0] o_pattern_select;
    logic       o_auto_mode;
    logic       o_pending;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned phase  = 0;

    // Reference model state
    bit          m_sync1 [2];
    bit          m_sync2 [2];
    bit          m_lvl   [2];
    bit          m_press [2];
    bit          m_hist  [2][DC];
    int unsigned m_hcnt  [2];
    bit          m_vsd;
    bit          m_auto;
    bit          m_pend;
    int unsigned m_pat;
    int unsigned m_fcnt;

    pattern_select_ctrl #(
        .NUM_PATTERNS    (NP),
        .DEBOUNCE_CYCLES (DC),
        .AUTO_FRAMES     (AF),
        .VS_ACTIVE_LOW   (VAL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_btn_next       (i_btn_next),
        .i_btn_mode       (i_btn_mode),
        .i_vs             (i_vs),
        .o_pattern_select (o_pattern_select),
        .o_auto_mode      (o_auto_mode),
        .o_pending        (o_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        bit fs;
        bit adv;
        bit raw [2];
        bit all_diff;
        raw[0] = i_btn_next;
        raw[1] = i_btn_mode;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_sync1[b] = 0; m_sync2[b] = 0; m_lvl[b] = 0; m_press[b] = 0; m_hcnt[b] = 0;
                for (int i = 0; i < DC; i++) m_hist[b][i] = 0;
            end
            m_vsd = 0; m_auto = 0; m_pend = 0; m_pat = 0; m_fcnt = 0;
        end else begin
            fs  = VAL ? (m_vsd && !i_vs) : (!m_vsd && i_vs);
            adv = 0;
            if (fs) begin
                if (m_pend) begin
                    adv = 1; m_pend = 0; m_fcnt = 0;
                end else if (m_auto) begin
                    m_fcnt++;
                    if (m_fcnt == AF) begin adv = 1; m_fcnt = 0; end
                end
            end
            if (adv) m_pat = (m_pat + 1) % NP;
            if (m_press[0]) m_pend = 1;
            if (m_press[1]) begin m_auto = !m_auto; m_fcnt = 0; end
            // A level is accepted once the last DC synced samples all differ from it.
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DC - 1; i++) m_hist[b][i] = m_hist[b][i+1];
                m_hist[b][DC-1] = m_sync2[b];
                if (m_hcnt[b] < DC) m_hcnt[b]++;
                all_diff = (m_hcnt[b] == DC);
                for (int i = 0; i < DC; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 0;
                m_press[b] = 0;
                if (all_diff) begin
                    m_lvl[b]   = !m_lvl[b];
                    m_press[b] = m_lvl[b];
                end
                m_sync2[b] = m_sync1[b];
                m_sync1[b] = raw[b];
            end
            m_vsd = i_vs;
        end
    endtask

    task automatic step();
        i_vs = ((phase % FRAME) >= 2);
        phase++;
        @(posedge clk);
        model_edge();
        #1;
        chk("pattern", 32'(o_pattern_select), 32'(m_pat));
        chk("auto",    32'(o_auto_mode),      32'(m_auto));
        chk("pending", 32'(o_pending),        32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int unsigned p);
        for (int i = 0; i < FRAME && (phase % FRAME) != p; i++) step();
    endtask

    task automatic press(input bit sel_mode, input int hi, input int lo);
        if (sel_mode) i_btn_mode = 1; else i_btn_next = 1;
        run(hi);
        i_btn_mode = 0;
        i_btn_next = 0;
        run(lo);
    endtask

    initial begin
        int unsigned seq [4];
        seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0;
        rst = 1; i_btn_next = 0; i_btn_mode = 0; i_vs = 1;

        // Reset with buttons toggling, then idle
        for (int i = 0; i < 3; i++) begin
            i_btn_next = i[0];
            i_btn_mode = !i[0];
            step();
        end
        rst = 0; i_btn_next = 0; i_btn_mode = 0;
        run(20);
        chk("reset_pattern", 32'(o_pattern_select), 32'd0);
        chk("reset_auto",    32'(o_auto_mode),      32'd0);
        chk("reset_pending", 32'(o_pending),        32'd0);

        // Bounce: 3-cycle glitch, then steady high
        wait_phase(3);
        i_btn_next = 1; run(3);
        i_btn_next = 0; run(2);
        i_btn_next = 1; run(6);
        chk("bounce_pend_early", 32'(o_pending), 32'd0);
        run(1);
        chk("bounce_pend_at7", 32'(o_pending), 32'd1);
        run(3);
        i_btn_next = 0;
        wait_phase(0);
        chk("bounce_before_fs", 32'(o_pattern_select), 32'd0);
        step();
        chk("bounce_after_fs", 32'(o_pattern_select), 32'd1);
        chk("bounce_pend_clr", 32'(o_pending), 32'd0);

        // Collapse: three presses within one frame give a single advance
        wait_phase(15);
        press(0, 4, 4);
        chk("collapse_mid", 32'(o_pattern_select), 32'd1);
        press(0, 4, 4);
        press(0, 4, 4);
        wait_phase(1);
        chk("collapse_adv", 32'(o_pattern_select), 32'd2);
        run(FRAME);
        chk("collapse_single", 32'(o_pattern_select), 32'd2);

        // Press pulse coinciding with fs is deferred to the next fs
        wait_phase(14);
        i_btn_next = 1; run(6);
        i_btn_next = 0; run(1);
        chk("simul_no_adv", 32'(o_pattern_select), 32'd2);
        chk("simul_pending", 32'(o_pending), 32'd1);
        run(5);
        wait_phase(1);
        chk("simul_adv", 32'(o_pattern_select), 32'd3);

        // Wrap from 0
        rst = 1; run(2); rst = 0;
        for (int k = 0; k < 4; k++) begin
            wait_phase(3);
            press(0, 6, 6);
            wait_phase(1);
            chk("wrap_seq", 32'(o_pattern_select), 32'(seq[k]));
        end

        // Auto mode: advance every AF frames
        wait_phase(3);
        press(1, 6, 6);
        chk("auto_enter", 32'(o_auto_mode), 32'd1);
        for (int f = 1; f <= 9; f++) begin
            wait_phase(1);
            chk("auto_frames", 32'(o_pattern_select), 32'((f / AF) % NP));
            run(1);
        end
        wait_phase(1);
        chk("auto_cnt1", 32'(o_pattern_select), 32'd3);
        wait_phase(3);
        press(0, 6, 6);
        wait_phase(1);
        chk("auto_next_adv", 32'(o_pattern_select), 32'd0);
        for (int f = 1; f <= 3; f++) begin
            run(1);
            wait_phase(1);
            chk("auto_restart", 32'(o_pattern_select), 32'((f == 3) ? 1 : 0));
        end

        // Reset mid-operation with a pending request in AUTO
        wait_phase(3);
        i_btn_next = 1; run(6);
        i_btn_next = 0; run(2);
        chk("midrst_pend_set", 32'(o_pending), 32'd1);
        rst = 1; run(2); rst = 0;
        chk("midrst_pattern", 32'(o_pattern_select), 32'd0);
        chk("midrst_auto",    32'(o_auto_mode),      32'd0);
        run(3 * FRAME);
        chk("midrst_hold_pattern", 32'(o_pattern_select), 32'd0);
        chk("midrst_hold_pend",    32'(o_pending),        32'd0);

        // Randomized bursts against the model
        for (int r = 0; r < 150; r++) begin
            i_btn_next = ($urandom_range(0, 2) == 0);
            i_btn_mode = ($urandom_range(0, 4) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            run(rst ? 1 : int'($urandom_range(1, 12)));
            rst = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
